// File: rtl/pcs_block_sync_rx.sv
// Per-lane 66b block lock: checks sync headers, requests gearbox slips, reports block lock.
// Optional PCS_BLOCK_SYNC_ERR_CNT_EN adds err_cnt_o, a saturating invalid-header count while locked.
module pcs_block_sync_rx #(
    parameter int UNLOCK_WIN_N = 64,
    parameter int LOCK_WIN_N   = 1024,
    parameter int INVLD_N      = 65,
    parameter int SLIP_WAIT_N  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    input  logic [1:0]  head_i,
    input  logic        signal_ok_i,
    output logic        slip_v_o,
    output logic        lock_v_o,
`ifdef PCS_BLOCK_SYNC_ERR_CNT_EN
    output logic [15:0] err_cnt_o,
`endif
    output logic [6:0]  invld_cnt_o
);
    localparam int WAIT_W = $clog2(SLIP_WAIT_N + 1);
    localparam logic [10:0]       UNLOCK_WIN = 11'(UNLOCK_WIN_N);
    localparam logic [10:0]       LOCK_WIN   = 11'(LOCK_WIN_N);
    localparam logic [6:0]        INVLD_LIM  = 7'(INVLD_N);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(SLIP_WAIT_N);

    // One-hot encoding keeps the state register trivially checkable.
    typedef enum logic [1:0] {
        TEST      = 2'b01,
        SLIP_WAIT = 2'b10
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_lock, w_lock_nxt;
    logic [10:0]       r_sh_cnt, w_sh_cnt_nxt;
    logic [6:0]        r_invld_cnt, w_invld_cnt_nxt;
    logic [WAIT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
    logic              w_sh_valid;
    logic              w_slip;
    logic [10:0]       w_win;
    logic [10:0]       w_sh_inc;
    logic [6:0]        w_invld_inc;
    logic [WAIT_W-1:0] w_wait_inc;

    assign w_sh_valid  = head_i[1] ^ head_i[0];
    assign w_win       = r_lock ? LOCK_WIN : UNLOCK_WIN;
    assign w_sh_inc    = r_sh_cnt + 11'd1;
    assign w_invld_inc = r_invld_cnt + 7'd1;
    assign w_wait_inc  = r_wait_cnt + WAIT_W'(1);

    always_comb begin
        w_state_nxt     = r_state;
        w_lock_nxt      = r_lock;
        w_sh_cnt_nxt    = r_sh_cnt;
        w_invld_cnt_nxt = r_invld_cnt;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_slip          = 1'b0;
        if (!signal_ok_i) begin
            w_state_nxt     = TEST;
            w_lock_nxt      = 1'b0;
            w_sh_cnt_nxt    = '0;
            w_invld_cnt_nxt = '0;
            w_wait_cnt_nxt  = '0;
        end else if (valid_i) begin
            case (r_state)
                TEST: begin
                    w_sh_cnt_nxt = w_sh_inc;
                    if (w_sh_valid) begin
                        if (w_sh_inc == w_win) begin
                            w_sh_cnt_nxt    = '0;
                            w_invld_cnt_nxt = '0;
                            if (r_invld_cnt == 7'd0) w_lock_nxt = 1'b1;
                        end
                    end else begin
                        w_invld_cnt_nxt = w_invld_inc;
                        if (w_invld_inc == INVLD_LIM || !r_lock) begin
                            w_slip          = 1'b1;
                            w_lock_nxt      = 1'b0;
                            w_sh_cnt_nxt    = '0;
                            w_invld_cnt_nxt = '0;
                            w_wait_cnt_nxt  = '0;
                            w_state_nxt     = SLIP_WAIT;
                        end else if (w_sh_inc == w_win) begin
                            w_sh_cnt_nxt    = '0;
                            w_invld_cnt_nxt = '0;
                        end
                    end
                end
                SLIP_WAIT: begin
                    // Headers are meaningless while the gearbox settles after a slip.
                    w_wait_cnt_nxt = w_wait_inc;
                    if (w_wait_inc == WAIT_LAST) begin
                        w_wait_cnt_nxt = '0;
                        w_state_nxt    = TEST;
                    end
                end
                default: w_state_nxt = TEST;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= TEST;
            r_lock      <= 1'b0;
            r_sh_cnt    <= '0;
            r_invld_cnt <= '0;
            r_wait_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_lock      <= w_lock_nxt;
            r_sh_cnt    <= w_sh_cnt_nxt;
            r_invld_cnt <= w_invld_cnt_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
        end
    end

    assign slip_v_o    = w_slip & ~reset;
    assign lock_v_o    = r_lock;
    assign invld_cnt_o = r_invld_cnt;

`ifdef PCS_BLOCK_SYNC_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset || !signal_ok_i) begin
            r_err_cnt <= '0;
        end else if (valid_i && !w_sh_valid && r_lock) begin
            r_err_cnt <= sat_inc16(r_err_cnt);
        end
    end

    assign err_cnt_o = r_err_cnt;
`endif

`ifdef FORMAL
    always_comb begin
        assert ($onehot(r_state));
        if (r_state == SLIP_WAIT) assert (!slip_v_o);
        assert (r_invld_cnt <= INVLD_LIM);
    end
`endif
endmodule
